// File: rtl/fft_frame_scheduler_pkg.sv
// Shared types and helpers for the FFT frame scheduler.
//   sched_state_t  : scheduler FSM encoding (IDLE, FILL, GAP)
//   FRAME_LEN_DEF  : default output beats per frame
//   SHIFT_DEF      : default number of zero LSBs appended below a sample
//   sat_inc16      : 16-bit increment that sticks at all-ones
package fft_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    GAP  = 2'd2
  } sched_state_t;

  localparam int unsigned FRAME_LEN_DEF = 1024;
  localparam int unsigned SHIFT_DEF     = 8;

  // Increment that saturates at 16'hFFFF instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/fft_frame_scheduler_if.sv
// Sample-in / beat-out handshake bundle of the FFT frame scheduler.
//   in_valid/in_data/in_ready     : codec sample strobe (in_ready is tied high)
//   out_valid/out_ready/out_data/out_last : FFT input stream
// master: the environment (codec + FFT side); slave: the scheduler.
interface fft_sched_if #(
  parameter int unsigned N = 16,
  parameter int unsigned W = 32
);
  import fft_sched_pkg::*;

  logic         in_valid;
  logic [N-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );

endinterface

// File: rtl/fft_frame_scheduler_decimator.sv
// Wrapping decimation counter.
//   clk, rst_n : clock, async active-low reset
//   clr        : hold the counter at zero (scheduler idle)
//   dec_m1     : decimation factor minus 1 (latched copy from the scheduler)
//   in_valid   : codec sample strobe
//   cand       : this sample is the one kept out of every dec_m1+1
module sample_decimator
  import fft_sched_pkg::*;
#(
  parameter int unsigned DEC_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [DEC_W-1:0] dec_m1,
  input  logic             in_valid,
  output logic             cand
);

  logic [DEC_W-1:0] dec_cnt_q;

  // Counter wraps to zero on the sample that matches dec_m1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_cnt_q <= '0;
    end else if (clr) begin
      dec_cnt_q <= '0;
    end else if (in_valid) begin
      dec_cnt_q <= (dec_cnt_q == dec_m1) ? '0 : dec_cnt_q + DEC_W'(1);
    end
  end

  assign cand = in_valid && !clr && (dec_cnt_q == dec_m1);

endmodule

// File: rtl/fft_frame_scheduler.sv
// Cuts the decimated codec sample stream into fixed-length FFT frames.
//   clk, rst_n  : adc_clk domain clock, async active-low reset
//   enable      : run request, only sampled at frame boundaries
//   dec_m1      : decimation factor minus 1 (latched at frame start)
//   frame_gap   : decimated samples discarded between frames (latched)
//   drop_clr    : synchronous clear of drop_count (wins over increment)
//   bus         : sample in / beat out handshakes (slave side)
//   frame_start : pulse coincident with beat 0 appearing on the output
//   frame_done  : high while the last beat of a frame handshakes
//   drop_count  : saturating count of candidates lost to back-pressure
//   busy        : scheduler is not idle
// W must be at least N + SHIFT.
module fft_frame_scheduler
  import fft_sched_pkg::*;
#(
  parameter int unsigned N         = 16,
  parameter int unsigned W         = 32,
  parameter int unsigned SHIFT     = SHIFT_DEF,
  parameter int unsigned FRAME_LEN = FRAME_LEN_DEF,
  parameter int unsigned DEC_W     = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [DEC_W-1:0] dec_m1,
  input  logic [15:0]      frame_gap,
  input  logic             drop_clr,
  fft_sched_if.slave       bus,
  output logic             frame_start,
  output logic             frame_done,
  output logic [15:0]      drop_count,
  output logic             busy
);

  localparam int unsigned    IDX_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_FILL = FILL;
  localparam logic [1:0] ST_GAP  = GAP;

  logic [1:0]       state_q,       state_d;
  logic [DEC_W-1:0] cfg_dec_q,     cfg_dec_d;
  logic [15:0]      cfg_gap_q,     cfg_gap_d;
  logic [IDX_W-1:0] frame_idx_q,   frame_idx_d;
  logic [15:0]      gap_cnt_q,     gap_cnt_d;
  logic             out_valid_q,   out_valid_d;
  logic [W-1:0]     out_data_q,    out_data_d;
  logic             out_last_q,    out_last_d;
  logic             frame_start_q, frame_start_d;
  logic [15:0]      drop_q,        drop_d;
  logic             busy_q,        busy_d;

  logic             cand;
  logic             drop_c;
  logic             reg_free_c;
  logic [W-1:0]     sample_word_c;

  // Decimation counter; held clear while idle so each run starts at phase 0.
  sample_decimator #(
    .DEC_W (DEC_W)
  ) u_dec (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (state_q == ST_IDLE),
    .dec_m1   (cfg_dec_q),
    .in_valid (bus.in_valid),
    .cand     (cand)
  );

  // Output register can take a new beat if empty or emptying this cycle.
  assign reg_free_c    = !out_valid_q || bus.out_ready;
  assign sample_word_c = W'($signed(bus.in_data)) << SHIFT;

  // Next-state and datapath decode.
  always_comb begin
    state_d       = state_q;
    cfg_dec_d     = cfg_dec_q;
    cfg_gap_d     = cfg_gap_q;
    frame_idx_d   = frame_idx_q;
    gap_cnt_d     = gap_cnt_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_last_d    = out_last_q;
    frame_start_d = 1'b0;
    drop_d        = drop_q;
    drop_c        = 1'b0;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d     = ST_FILL;
          cfg_dec_d   = dec_m1;
          cfg_gap_d   = frame_gap;
          frame_idx_d = '0;
          gap_cnt_d   = '0;
        end
      end

      ST_FILL: begin
        if (cand) begin
          if (reg_free_c) begin
            out_valid_d   = 1'b1;
            out_data_d    = sample_word_c;
            out_last_d    = (frame_idx_q == LAST_IDX);
            frame_start_d = (frame_idx_q == '0);
            // FRAME_LEN is a power of two, so this wraps to 0 after the last beat.
            frame_idx_d   = frame_idx_q + IDX_W'(1);
            if (frame_idx_q == LAST_IDX) begin
              if (cfg_gap_q != 16'd0) begin
                state_d   = ST_GAP;
                gap_cnt_d = cfg_gap_q;
              end else if (enable) begin
                cfg_dec_d = dec_m1;
                cfg_gap_d = frame_gap;
              end else begin
                state_d = ST_IDLE;
              end
            end
          end else begin
            drop_c = 1'b1;
          end
        end
      end

      ST_GAP: begin
        // Gap candidates are discarded on purpose and never counted as drops.
        if (cand) begin
          gap_cnt_d = (gap_cnt_q == 16'd0) ? 16'd0 : gap_cnt_q - 16'd1;
          if (gap_cnt_q <= 16'd1) begin
            if (enable) begin
              state_d   = ST_FILL;
              cfg_dec_d = dec_m1;
              cfg_gap_d = frame_gap;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (drop_clr) begin
      drop_d = '0;
    end else if (drop_c) begin
      drop_d = sat_inc16(drop_q);
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cfg_dec_q     <= '0;
      cfg_gap_q     <= '0;
      frame_idx_q   <= '0;
      gap_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_last_q    <= 1'b0;
      frame_start_q <= 1'b0;
      drop_q        <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cfg_dec_q     <= cfg_dec_d;
      cfg_gap_q     <= cfg_gap_d;
      frame_idx_q   <= frame_idx_d;
      gap_cnt_q     <= gap_cnt_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_last_q    <= out_last_d;
      frame_start_q <= frame_start_d;
      drop_q        <= drop_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.in_ready  = 1'b1;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign frame_start   = frame_start_q;
  // Marks the handshake of the last beat itself, so it follows out_ready directly.
  assign frame_done    = out_valid_q && bus.out_ready && out_last_q;
  assign drop_count    = drop_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_fft_frame_scheduler.sv
// Directed bench for fft_frame_scheduler. A second instance runs the long
// drop-counter saturation sequence alongside the first frame.
module tb_fft_frame_scheduler;
  import fft_sched_pkg::*;

  localparam int FL = 1024;

  logic        clk;
  logic        rst_n;
  logic        enable,   sat_enable;
  logic [5:0]  dec_m1,   sat_dec;
  logic [15:0] frame_gap, sat_gap;
  logic        drop_clr, sat_clr;
  logic        frame_start, frame_done, busy;
  logic        sat_start, sat_done, sat_busy;
  logic [15:0] drop_count, sat_drop;

  int vectors = 0;
  int miscompares = 0;

  int beats, lasts, last_bad, starts, start_bad, dones, data_bad;
  logic [31:0] first_val, probe_val;

  fft_sched_if #(.N(16), .W(32)) s_if ();
  fft_sched_if #(.N(16), .W(32)) t_if ();

  fft_frame_scheduler dut (
    .clk (clk), .rst_n (rst_n), .enable (enable), .dec_m1 (dec_m1),
    .frame_gap (frame_gap), .drop_clr (drop_clr), .bus (s_if.slave),
    .frame_start (frame_start), .frame_done (frame_done),
    .drop_count (drop_count), .busy (busy)
  );

  fft_frame_scheduler dut_sat (
    .clk (clk), .rst_n (rst_n), .enable (sat_enable), .dec_m1 (sat_dec),
    .frame_gap (sat_gap), .drop_clr (sat_clr), .bus (t_if.slave),
    .frame_start (sat_start), .frame_done (sat_done),
    .drop_count (sat_drop), .busy (sat_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected output word for ramp sample number sidx.
  function automatic logic [31:0] exp_word(input int sidx);
    logic [15:0] v;
    v = 16'(sidx);
    exp_word = {{8{v[15]}}, v, 8'h00};
  endfunction

  // Feed a ramp on every cycle with out_ready high and tally the beats seen.
  task automatic stream(input int frames, input int dec, input int gap,
                        input int en_off, input int probe, input int max_cyc);
    int sidx;
    int cand;
    logic exp_last;
    beats = 0; lasts = 0; last_bad = 0; starts = 0; start_bad = 0;
    dones = 0; data_bad = 0; first_val = '0; probe_val = '0;
    sidx = 0;
    s_if.in_valid = 1'b1;
    s_if.in_data  = 16'(sidx);
    for (int c = 0; c < max_cyc; c++) begin
      tick();
      sidx++;
      s_if.in_data = 16'(sidx);
      if (frame_start) begin
        starts++;
        if (!s_if.out_valid || (beats % FL) != 0) start_bad++;
      end
      if (s_if.out_valid) begin
        cand = beats + (beats / FL) * gap;
        exp_last = ((beats % FL) == FL - 1);
        if (s_if.out_data !== exp_word(cand * (dec + 1) + dec)) data_bad++;
        if (s_if.out_last !== exp_last) last_bad++;
        if (s_if.out_last) lasts++;
        if (frame_done) dones++;
        if (beats == 0) first_val = s_if.out_data;
        if (beats == probe) probe_val = s_if.out_data;
        beats++;
        if (beats == en_off) enable = 1'b0;
        if (beats == frames * FL) break;
      end
    end
    s_if.in_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0; dec_m1 = '0; frame_gap = '0; drop_clr = 1'b0;
    sat_enable = 1'b0; sat_dec = '0; sat_gap = '0; sat_clr = 1'b0;
    s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.out_ready = 1'b1;
    t_if.in_valid = 1'b0; t_if.in_data = '0; t_if.out_ready = 1'b1;

    // Reset state
    #1;
    check("rst out_valid",   32'(s_if.out_valid), 32'h0);
    check("rst out_data",    s_if.out_data,       32'h0);
    check("rst out_last",    32'(s_if.out_last),  32'h0);
    check("rst frame_start", 32'(frame_start),    32'h0);
    check("rst frame_done",  32'(frame_done),     32'h0);
    check("rst drop_count",  32'(drop_count),     32'h0);
    check("rst busy",        32'(busy),           32'h0);
    check("rst in_ready",    32'(s_if.in_ready),  32'h1);
    #13;
    rst_n = 1'b1;
    tick();

    // Basic frame (decimate by 64) alongside drop-counter saturation
    fork
      begin
        enable = 1'b1; dec_m1 = 6'd63; frame_gap = 16'd0;
        tick();
        stream(1, 63, 0, 100, 512, 70000);
      end
      begin
        sat_enable = 1'b1;
        tick();
        t_if.out_ready = 1'b0;
        t_if.in_valid = 1'b1;
        t_if.in_data = 16'h5A5A;
        tick();
        check("sat first load", t_if.out_data, 32'h005A5A00);
        repeat (65534) tick();
        check("sat drop FFFE", 32'(sat_drop), 32'h0000FFFE);
        tick();
        check("sat drop FFFF", 32'(sat_drop), 32'h0000FFFF);
        repeat (5) tick();
        check("sat drop held", 32'(sat_drop), 32'h0000FFFF);
        check("sat data held", t_if.out_data, 32'h005A5A00);
        sat_clr = 1'b1;
        tick();
        check("sat clr priority", 32'(sat_drop), 32'h0);
        sat_clr = 1'b0;
        tick();
        check("sat count after clr", 32'(sat_drop), 32'h1);
        t_if.in_valid = 1'b0;
        sat_enable = 1'b0;
      end
    join
    check("basic beats",      32'(beats),     32'd1024);
    check("basic lasts",      32'(lasts),     32'd1);
    check("basic last pos",   32'(last_bad),  32'd0);
    check("basic data",       32'(data_bad),  32'd0);
    check("basic starts",     32'(starts),    32'd1);
    check("basic start pos",  32'(start_bad), 32'd0);
    check("basic dones",      32'(dones),     32'd1);
    check("basic beat0",      first_val,      32'h00003F00);
    check("basic beat512",    probe_val,      32'hFF803F00);
    check("basic drops",      32'(drop_count), 32'h0);
    check("basic idle",       32'(busy),      32'h0);

    // Disable at beat 500: frame still completes, then idle
    enable = 1'b1; dec_m1 = 6'd0; frame_gap = 16'd0;
    tick();
    check("dis busy", 32'(busy), 32'h1);
    stream(1, 0, 0, 500, 1023, 1200);
    check("dis beats",     32'(beats),    32'd1024);
    check("dis last pos",  32'(last_bad), 32'd0);
    check("dis data",      32'(data_bad), 32'd0);
    check("dis beat1023",  probe_val,     32'h0003FF00);
    check("dis done",      32'(frame_done), 32'h1);
    check("dis idle",      32'(busy),     32'h0);

    // Gap of 5 after frame 1; config change after latch must not matter
    enable = 1'b1; frame_gap = 16'd5;
    tick();
    frame_gap = 16'd0;
    stream(2, 0, 5, 1500, 1024, 2200);
    check("gap beats",     32'(beats),     32'd2048);
    check("gap data",      32'(data_bad),  32'd0);
    check("gap last pos",  32'(last_bad),  32'd0);
    check("gap starts",    32'(starts),    32'd2);
    check("gap start pos", 32'(start_bad), 32'd0);
    check("gap dones",     32'(dones),     32'd2);
    check("gap f2 beat0",  probe_val,      32'h00040500);
    check("gap no drops",  32'(drop_count), 32'h0);
    check("gap idle",      32'(busy),      32'h0);

    // Back-pressure: first sample held, 10 candidates dropped
    enable = 1'b1; dec_m1 = 6'd0;
    tick();
    s_if.out_ready = 1'b0;
    s_if.in_valid = 1'b1;
    s_if.in_data = 16'h1234;
    tick();
    check("bp load",  s_if.out_data,    32'h00123400);
    check("bp start", 32'(frame_start), 32'h1);
    for (int i = 0; i < 10; i++) begin
      s_if.in_data = 16'(16'h2000 + i);
      tick();
    end
    check("bp drops", 32'(drop_count),    32'd10);
    check("bp held",  s_if.out_data,      32'h00123400);
    check("bp valid", 32'(s_if.out_valid), 32'h1);

    // Same-cycle handshake and reload
    s_if.out_ready = 1'b1;
    s_if.in_data = 16'h8001;
    tick();
    check("refill data",  s_if.out_data,      32'hFF800100);
    check("refill valid", 32'(s_if.out_valid), 32'h1);
    check("refill drops", 32'(drop_count),    32'd10);
    check("refill start", 32'(frame_start),   32'h0);

    // Asynchronous reset mid-frame
    s_if.out_ready = 1'b0;
    s_if.in_valid = 1'b0;
    @(posedge clk);
    #3;
    check("pre-rst valid", 32'(s_if.out_valid), 32'h1);
    rst_n = 1'b0;
    #1;
    check("arst out_valid",  32'(s_if.out_valid), 32'h0);
    check("arst out_data",   s_if.out_data,       32'h0);
    check("arst out_last",   32'(s_if.out_last),  32'h0);
    check("arst drop_count", 32'(drop_count),     32'h0);
    check("arst busy",       32'(busy),           32'h0);
    check("arst frame_done", 32'(frame_done),     32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b1;
    s_if.out_ready = 1'b1;
    tick();
    s_if.in_valid = 1'b1;
    s_if.in_data = 16'h0042;
    tick();
    s_if.in_valid = 1'b0;
    check("restart valid", 32'(s_if.out_valid), 32'h1);
    check("restart beat0", s_if.out_data,       32'h00004200);
    check("restart start", 32'(frame_start),    32'h1);
    check("restart last",  32'(s_if.out_last),  32'h0);
    enable = 1'b0;
    tick();
    check("restart pulse", 32'(frame_start), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fft_frame_scheduler.md
# fft_frame_scheduler

Sequences the decimated audio sample stream into fixed-length FFT frames. Sits between `audio_codec_data` and `fft_stream` in the `adc_clk` domain. Replaces the ad-hoc decimation counter with:
- a configurable decimation factor;
- frame counting with a last-beat marker;
- an optional inter-frame gap;
- clean enable/disable at frame boundaries;
- a saturating count of samples lost to FFT back-pressure.

## Interface
Parameters:
- `N`, 16, input sample width (two's complement)
- `W`, 32, output word width; requires `W >= N + SHIFT`
- `SHIFT`, 8, zero LSBs appended below the sample
- `FRAME_LEN`, 1024, output beats per frame (power of two)
- `DEC_W`, 6, width of the decimation-factor field (factor up to 2^DEC_W)

Ports:
- `clk` in 1: `adc_clk` domain clock
- `rst_n` in 1: asynchronous, active-low reset
- `enable` in 1: run request, sampled at frame boundaries
- `dec_m1` in DEC_W: decimation factor minus 1 (0 means no decimation)
- `frame_gap` in 16: decimated samples discarded between frames
- `drop_clr` in 1: synchronous clear of `drop_count`
- `in_valid` in 1: codec sample strobe (no back-pressure upstream)
- `in_data` in N: codec sample
- `in_ready` out 1: constant 1; the codec cannot stall
- `out_valid` out 1: FFT input valid
- `out_ready` in 1: FFT input ready
- `out_data` out W: sign-extended, left-shifted sample
- `out_last` out 1: marks beat FRAME_LEN-1 of a frame
- `frame_start` out 1: one-cycle pulse when beat 0 is loaded
- `frame_done` out 1: one-cycle pulse when the last beat handshakes
- `drop_count` out 16: saturating count of dropped decimated samples
- `busy` out 1: state != IDLE

## Operation
- States are IDLE, FILL and GAP.
- **IDLE:** if `enable` is high, latch `dec_m1` and `frame_gap`, clear the decimation counter and frame index, and go to FILL. All input samples are ignored.
- **Decimation:** `dec_cnt` increments on each `in_valid` outside IDLE and wraps at the latched `dec_m1`. A sample arriving with `dec_cnt == dec_m1` is a *candidate*.
- **FILL, candidate handling:**
  - If the output register is free, load the candidate. The register is free when `!out_valid`, or when `out_valid && out_ready` in the same cycle.
  - A load sets `out_valid` and `out_data = {sign-ext(in_data), SHIFT'b0}`, and sets `out_last` iff `frame_idx == FRAME_LEN-1`. `frame_idx` then increments.
  - If the register is not free, the candidate is dropped. `drop_count` increments (saturating at 16'hFFFF) and `frame_idx` is unchanged.
- **End of frame:** on loading beat FRAME_LEN-1, `frame_idx` wraps to 0. The next state is:
  - GAP if the latched `frame_gap` is nonzero;
  - else FILL if `enable` is high, re-latching the config;
  - else IDLE.
- **GAP:**
  - Each candidate decrements `gap_cnt`, which is loaded from `frame_gap`; candidates are not counted as drops.
  - When `gap_cnt` reaches 0: go to FILL if `enable` is high (re-latch config), else IDLE.
- **Disable mid-frame:** deasserting `enable` during FILL never truncates a frame.
- **Output register:** `out_valid` clears on handshake unless it is reloaded in the same cycle.
- **Pulses:** `frame_done` pulses on the cycle `out_valid && out_ready && out_last`.
- **`drop_clr`:** takes priority over a same-cycle increment.

## Timing
- **Reset values:**
  - IDLE; `out_valid`, `out_last`, `frame_start`, `frame_done` = 0;
  - `out_data` = 0; `drop_count` = 0;
  - `dec_cnt`, `frame_idx`, `gap_cnt` = 0; `in_ready` = 1.
- **Latency:** a candidate on cycle t produces `out_valid` on t+1. `frame_start` is asserted on t+1, coincident with beat 0.
- **Output stability:** `out_data` and `out_last` are stable while `out_valid && !out_ready`.
- **Asynchronous reset mid-frame:** all state is discarded immediately. No partial `frame_done` is issued.
- **Config inputs:** changes take effect only at the next latch point. They are sampled, not continuously used.

## Structure
- **Package `fft_sched_pkg`:**
  - `typedef enum logic [1:0] {IDLE, FILL, GAP} sched_state_t`;
  - `localparam` defaults for `FRAME_LEN` and `SHIFT`;
  - a `sat_inc16` function.
- **Sub-module `sample_decimator`:**
  - ports: `clk`, `rst_n`, `clr`, `dec_m1`, `in_valid`, `cand`;
  - contains the wrapping counter only.
- **Top level:** keeps the FSM, frame/gap counters, output register and drop counter.

## Test plan
- **Basic frame:** `dec_m1` = 63, `enable` = 1, `out_ready` = 1, ramp input on every `in_valid` -> exactly 1024 beats with values equal to every 64th sample; `out_last` only on beat 1023; one `frame_start` and one `frame_done`; `drop_count` = 0.
- **Back-pressure:** `dec_m1` = 0, `out_ready` low for 10 cycles with continuous `in_valid` -> the first sample is held stable and `drop_count` increments by 10. Hold `drop_count` at 16'hFFFF -> it saturates there. Assert `drop_clr` -> it reads 0.
- **Same-cycle refill:** `out_valid` = 1 with `out_ready` and a candidate arriving in the same cycle -> no drop, new data on the next cycle, and `out_valid` stays high.
- **Gap:** `frame_gap` = 5 -> after beat 1023, 5 candidates are discarded without counting as drops; beat 0 of frame 2 is the 6th candidate.
- **Disable and reset:** deassert `enable` at beat 500 -> the frame completes to 1023, the block goes to IDLE, and `busy` drops. Assert `rst_n` low mid-frame -> all outputs reach their reset values asynchronously, and the next frame restarts at index 0.
